// File: rtl/mem_access_stage_if.sv
// Data-memory request/response bus between the MEM-stage initiator and the memory responder.
// master = pipeline stage (issues requests), slave = data memory (grants and returns read data).
interface mem_access_stage_if #(
  parameter int ADDR_W = 5
);
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [31:0]       dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_gnt, dm_rvalid, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_gnt, dm_rvalid, dm_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues load/store requests over a req/gnt/rvalid bus, stalls upstream while busy.
// Optional macro MISALIGN_TRAP_EN: memory ops with a non-word-aligned address trap instead of issuing.
//
// state  | meaning
// IDLE   | no access outstanding; accepts a new instruction when ex_valid
// ACCESS | dm_req high, request fields held until dm_gnt
// WAIT   | load granted, waiting for dm_rvalid
module mem_access_stage #(
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ex_valid,
  input  logic                ex_mem_read,
  input  logic                ex_mem_write,
  input  logic                ex_reg_write,
  input  logic [31:0]         ex_alu_result,
  input  logic [31:0]         ex_rt_data,
  input  logic [4:0]          ex_dest,
  output logic                stall,
  mem_access_stage_if.master  dm,
  output logic                wb_valid,
  output logic                wb_reg_write,
  output logic [4:0]          wb_dest,
  output logic [31:0]         wb_data,
  output logic                bus_err
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]  cnt;
  logic              we_q;
  logic              reg_write_q;
  logic [4:0]        dest_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic accept, is_mem, misalign, trap, start, retire_alu;
  logic store_done, load_done, expired, abort;

  assign accept     = (state == IDLE) && ex_valid;
  assign is_mem     = ex_mem_read || ex_mem_write;
`ifdef MISALIGN_TRAP_EN
  assign misalign   = (ex_alu_result[1:0] != 2'b00);
`else
  assign misalign   = 1'b0;
`endif
  assign trap       = accept && is_mem && misalign;
  assign start      = accept && is_mem && !misalign;
  assign retire_alu = accept && !is_mem;
  assign expired    = (cnt == CNT_W'(TIMEOUT - 1));

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = ACCESS;
      end
      ACCESS: begin
        if (store_done || load_done || abort) state_nxt = IDLE;
        else if (dm.dm_gnt)                   state_nxt = WAIT;
      end
      WAIT: begin
        if (load_done || abort) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // outputs and completion events; completion takes priority over timeout abort
  always_comb begin
    stall      = 1'b0;
    dm.dm_req  = 1'b0;
    dm.dm_we   = 1'b0;
    store_done = 1'b0;
    load_done  = 1'b0;
    abort      = 1'b0;
    case (state)
      ACCESS: begin
        stall      = 1'b1;
        dm.dm_req  = 1'b1;
        dm.dm_we   = we_q;
        store_done = dm.dm_gnt && we_q;
        load_done  = dm.dm_gnt && !we_q && dm.dm_rvalid;
        abort      = expired && !store_done && !load_done;
      end
      WAIT: begin
        stall     = 1'b1;
        load_done = dm.dm_rvalid;
        abort     = expired && !load_done;
      end
      default: ;
    endcase
  end

  assign dm.dm_addr  = addr_q;
  assign dm.dm_wdata = wdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if (state != IDLE) begin
      cnt <= cnt + 1'b1;
    end
  end

  // a load with the write bit also set is treated as a plain load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q        <= 1'b0;
      reg_write_q <= 1'b0;
      dest_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else if (accept) begin
      we_q        <= ex_mem_write && !ex_mem_read;
      reg_write_q <= ex_reg_write;
      dest_q      <= ex_dest;
      addr_q      <= ex_alu_result[ADDR_W+1:2];
      wdata_q     <= ex_rt_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_dest      <= '0;
      wb_data      <= '0;
      bus_err      <= 1'b0;
    end else begin
      wb_valid <= retire_alu || trap || store_done || load_done || abort;
      bus_err  <= trap || abort;
      if (retire_alu) begin
        wb_data      <= ex_alu_result;
        wb_dest      <= ex_dest;
        wb_reg_write <= ex_reg_write && (ex_dest != 5'd0);
      end else if (trap) begin
        wb_data      <= '0;
        wb_dest      <= ex_dest;
        wb_reg_write <= 1'b0;
      end else if (load_done) begin
        wb_data      <= dm.dm_rdata;
        wb_dest      <= dest_q;
        wb_reg_write <= reg_write_q && (dest_q != 5'd0);
      end else if (store_done) begin
        wb_dest      <= dest_q;
        wb_reg_write <= 1'b0;
      end else if (abort) begin
        wb_data      <= '0;
        wb_dest      <= dest_q;
        wb_reg_write <= 1'b0;
      end
    end
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Initiator side of the data-memory interface: the pipeline MEM stage that issues load/store requests to the data memory responder and collects read data.
- Sits between the EX/MEM and MEM/WB pipeline boundaries.
- Uses a req/gnt/rvalid handshake so the responder may have variable latency.
- Stalls the upstream pipeline while an access is outstanding and produces registered MEM/WB outputs.

Parameters:
ADDR_W, 5, word-address width driven to the data memory (32 words by default)
TIMEOUT, 16, max cycles an access may stay outstanding before abort (≥2)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
ex_valid  in  1  EX/MEM holds a valid instruction
ex_mem_read  in  1  instruction is a load
ex_mem_write  in  1  instruction is a store (read and write both high: treated as load, write ignored)
ex_reg_write  in  1  instruction writes the register file
ex_alu_result  in  32  byte address for memory ops, result for non-memory ops
ex_rt_data  in  32  store data
ex_dest  in  5  destination register
stall  out  1  hold upstream; equals (state != IDLE)
dm_req  out  1  request to data memory
dm_we  out  1  1 = write, 0 = read; valid with dm_req
dm_addr  out  ADDR_W  word address = ex_alu_result[ADDR_W+1:2], captured
dm_wdata  out  32  captured store data
dm_gnt  in  1  responder accepts the request this cycle
dm_rvalid  in  1  read data valid
dm_rdata  in  32  read data
wb_valid  out  1  one-cycle pulse per retired instruction
wb_reg_write  out  1  write-back enable
wb_dest  out  5  write-back register
wb_data  out  32  write-back data
bus_err  out  1  one-cycle pulse on timeout or trap

Behaviour:
- Reset (async): state IDLE, timeout counter 0, all outputs 0.
- States: IDLE, ACCESS (dm_req high, awaiting dm_gnt), WAIT (load granted, awaiting dm_rvalid).
- Acceptance:
  - An instruction is accepted only in IDLE with ex_valid=1.
  - stall=0 in IDLE, so upstream advances at the same edge.
  - Op fields, address and store data are captured at the accepting edge.
- Non-memory op in IDLE:
  - Next cycle: wb_valid=1, wb_data=ex_alu_result, wb_dest=ex_dest, wb_reg_write=ex_reg_write.
  - Latency 1; stays in IDLE.
- Memory op in IDLE: go to ACCESS.
- ACCESS:
  - dm_req=1; dm_we/dm_addr/dm_wdata held stable until dm_gnt.
  - Store with gnt: go to IDLE; next cycle wb_valid=1, wb_reg_write=0.
  - Load with gnt and no rvalid: go to WAIT.
  - Load with gnt and rvalid in the same cycle: complete immediately.
- WAIT: dm_req=0. On dm_rvalid, go to IDLE; next cycle wb_valid=1, wb_data=dm_rdata, wb_reg_write=captured reg_write.
- Minimum latency: store 2 cycles, load 2 cycles (gnt+rvalid in the same cycle).
- dm_rvalid is ignored in IDLE and in ACCESS before gnt.
- wb_reg_write is forced to 0 when wb_dest==0.
- wb_* outputs hold their values between pulses; only wb_valid returns to 0.
- Timeout:
  - Counter clears on accept and increments each cycle in ACCESS/WAIT.
  - Abort when the counter reaches TIMEOUT−1 with no completion that cycle.
  - On abort: go to IDLE and drop dm_req. Next cycle: bus_err=1, wb_valid=1, wb_reg_write=0, wb_data=0.
- Reset mid-access: abort immediately; a later stray dm_rvalid is ignored.
- Simultaneous abort and completion in the same cycle: completion wins.

Optional Feature:
- MISALIGN_TRAP_EN defined:
  - A memory op with ex_alu_result[1:0]!=0 issues no request and stays in IDLE.
  - Next cycle: bus_err=1, wb_valid=1, wb_reg_write=0.
- Undefined: low two address bits are ignored and the access proceeds.

Test Plan:
- Load addr 0x0C, ex_dest=8, gnt+rvalid same cycle with rdata=300 → stall high 1 cycle; wb_valid pulse with wb_data=300, wb_dest=8, wb_reg_write=1; dm_addr=3.
- Store 1234 to 0x14, gnt delayed 3 cycles → dm_req/dm_we=1, dm_addr=5, dm_wdata=1234 stable for 4 cycles; stall 4 cycles; wb_valid with wb_reg_write=0.
- Load, gnt at cycle 1, rvalid at cycle 4 with rdata=0xA5A5A5A5 → dm_req drops after gnt; wb_data=0xA5A5A5A5; back-to-back non-memory op retires 1 cycle after stall drops.
- Load, never granted, TIMEOUT=16 → dm_req drops after 16 cycles; bus_err and wb_valid pulse; wb_reg_write=0; next instruction accepted.
- reset asserted while in WAIT, then stray rvalid → all outputs 0 asynchronously; no wb_valid afterwards.
- Load to 0x0D with macro defined → no dm_req; bus_err pulse next cycle. With macro undefined → dm_addr=3, normal load.
